mult_stage_p: RTL

- Parametrised successor to the DSP48A1 multiplier input and M-register stage.
- Datapath: optional D±B pre-adder, then A×(B-path) multiplier, then a configurable-depth M pipeline.
- Adds generic widths, selectable pipeline depths, signed/unsigned arithmetic, per-stage opmode alignment, and a valid pipeline.
- Feeds the X-mux of the post-adder and drives the B cascade to the next slice.

---
 rtl/mult_stage_pkg.sv | 29 ++
 rtl/mult_stage_p_dff_mux.sv | 27 ++
 rtl/mult_stage_p.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_stage_pkg.sv
// Shared constants and helpers for the parametrised multiplier input / M-register stage.
package mult_stage_pkg;

  localparam string B_DIRECT  = "DIRECT";
  localparam string B_CASCADE = "CASCADE";

  localparam int PRE_MAX  = 1;
  localparam int POST_MAX = 1;
  localparam int M_MAX    = 3;

  // Widest operand the extension helper can handle; WA+WB must fit.
  localparam int EXT_W = 64;

  function automatic int mult_latency(input int pre, input int post, input int m);
    return pre + post + m;
  endfunction

  // Sign- or zero-extend the low 'width' bits of x to EXT_W bits.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] x,
                                           input bit               is_signed,
                                           input int               width);
    logic [EXT_W-1:0] hi;
    logic             sgn_bit;
    hi      = ~((EXT_W'(1) << width) - EXT_W'(1));
    sgn_bit = is_signed && (((x >> (width - 1)) & EXT_W'(1)) != '0);
    return sgn_bit ? (x | hi) : (x & ~hi);
  endfunction

endpackage

// File: rtl/mult_stage_p_dff_mux.sv
// Register-or-bypass stage: a clock-enabled register when PIPELINE=1, a wire when PIPELINE=0.
module dff_mux #(
  parameter int SIZE     = 1,
  parameter int PIPELINE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  if (PIPELINE != 0) begin : g_reg
    logic [SIZE-1:0] q_r;
    // NOTE: reset outranks ce, and nonblocking updates let chained stages sample pre-edge values.
    always_ff @(posedge clk) begin
      if (rst)     q_r <= '0;
      else if (ce) q_r <= d;
    end
    assign q = q_r;
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q          = d;
  end

endmodule

// File: rtl/mult_stage_p.sv
// DSP48A1-style multiplier front end: optional D+/-B pre-adder, A x B multiplier and
// a configurable M pipeline, with opmode bits and a valid flag travelling alongside the data.
module mult_stage_p
  import mult_stage_pkg::*;
#(
  parameter int    WA         = 18,
  parameter int    WB         = 18,
  parameter int    SIGNED     = 1,
  parameter string B_INPUT    = "DIRECT",
  parameter int    PRE_DEPTH  = 1,
  parameter int    POST_DEPTH = 1,
  parameter int    M_DEPTH    = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WA-1:0]    A,
  input  logic [WB-1:0]    B,
  input  logic [WB-1:0]    D,
  input  logic [WB-1:0]    BCIN,
  input  logic             OPMODE4,
  input  logic             OPMODE6,
  input  logic             IN_VALID,
  input  logic             CEP,
  input  logic             CE1,
  input  logic             CEM,
  output logic [WB-1:0]    BCOUT,
  output logic [WA+WB-1:0] PRODUCT,
  output logic             OUT_VALID
);

  localparam int WP   = WA + WB;
  localparam int S0_W = WA + 2 * WB + 3;

  if (PRE_DEPTH < 0 || PRE_DEPTH > PRE_MAX) begin : g_err_pre
    $error("mult_stage_p: PRE_DEPTH %0d out of range", PRE_DEPTH);
  end
  if (POST_DEPTH < 0 || POST_DEPTH > POST_MAX) begin : g_err_post
    $error("mult_stage_p: POST_DEPTH %0d out of range", POST_DEPTH);
  end
  if (M_DEPTH < 0 || M_DEPTH > M_MAX) begin : g_err_m
    $error("mult_stage_p: M_DEPTH %0d out of range", M_DEPTH);
  end
  if (mult_latency(PRE_DEPTH, POST_DEPTH, M_DEPTH) > PRE_MAX + POST_MAX + M_MAX) begin : g_err_lat
    $error("mult_stage_p: latency out of range");
  end
  if (B_INPUT != B_DIRECT && B_INPUT != B_CASCADE) begin : g_err_bin
    $error("mult_stage_p: illegal B_INPUT %s", B_INPUT);
  end
  if (WP > EXT_W) begin : g_err_w
    $error("mult_stage_p: WA+WB exceeds %0d", EXT_W);
  end

  logic [WB-1:0] b_src;
  if (B_INPUT == B_CASCADE) begin : g_b_casc
    logic unused_b;
    assign unused_b = ^B;
    assign b_src    = BCIN;
  end else begin : g_b_direct
    logic unused_bcin;
    assign unused_bcin = ^BCIN;
    assign b_src       = B;
  end

  // Stage 0: operands, opmodes and valid captured together so opmodes follow their sample.
  logic [WA-1:0] a0;
  logic [WB-1:0] b0, d0;
  logic          op4_0, op6_0, v0;

  dff_mux #(.SIZE(S0_W), .PIPELINE(PRE_DEPTH)) u_pre (
    .clk (CLK),
    .rst (RST),
    .ce  (CEP),
    .d   ({IN_VALID, OPMODE6, OPMODE4, D, b_src, A}),
    .q   ({v0, op6_0, op4_0, d0, b0, a0})
  );

  // Pre-adder wraps modulo 2^WB by construction of the WB-bit result.
  logic [WB-1:0] pd, b_sel;
  assign pd    = op6_0 ? (d0 - b0) : (d0 + b0);
  assign b_sel = op4_0 ? pd : b0;

  logic [WA-1:0] a1;
  logic [WB-1:0] b1;
  logic          v1;

  dff_mux #(.SIZE(WA + WB + 1), .PIPELINE(POST_DEPTH)) u_post (
    .clk (CLK),
    .rst (RST),
    .ce  (CE1),
    .d   ({v0, b_sel, a0}),
    .q   ({v1, b1, a1})
  );

  assign BCOUT = b1;

  // Operands extended to the full product width, so the product cannot overflow.
  logic [WP-1:0] prod;
  assign prod = WP'(ext(EXT_W'(a1), SIGNED != 0, WA)) * WP'(ext(EXT_W'(b1), SIGNED != 0, WB));

  logic [WP:0] m_chain [M_DEPTH+1];
  assign m_chain[0] = {v1, prod};

  for (genvar i = 0; i < M_DEPTH; i++) begin : g_m
    dff_mux #(.SIZE(WP + 1), .PIPELINE(1)) u_m (
      .clk (CLK),
      .rst (RST),
      .ce  (CEM),
      .d   (m_chain[i]),
      .q   (m_chain[i+1])
    );
  end

  assign {OUT_VALID, PRODUCT} = m_chain[M_DEPTH];

endmodule
